mem_access_stage: RTL and testbench

- Memory-access stage directly downstream of the execute stage. It consumes the ALU result (effective address or plain result), store data and control bits, and performs byte/half/word loads and stores over a req/ack data-memory handshake.
- It produces a registered writeback packet for the register-file write stage.
- While a memory transaction is outstanding it stalls execute through in_ready.

---
 rtl/mem_access_stage_pkg.sv | 39 +++
 rtl/mem_access_stage_align.sv | 53 +++++
 rtl/mem_access_stage.sv | 159 +++++++++++++++
 tb/tb_mem_access_stage.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared types for the memory-access stage.
// Size codes, FSM states and the writeback packet.
package mem_access_stage_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  localparam int WB_RD_W   = 5;
  localparam int WB_DATA_W = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic                 valid;
    logic [WB_RD_W-1:0]   rd;
    logic [WB_DATA_W-1:0] data;
    logic                 reg_write;
  } wb_pkt_t;

  function automatic logic lsu_is_b(input logic [2:0] f3);
    return (f3 == LSU_B) || (f3 == LSU_BU);
  endfunction

  function automatic logic lsu_is_h(input logic [2:0] f3);
    return (f3 == LSU_H) || (f3 == LSU_HU);
  endfunction

  // Anything that is not a byte/half code runs as a word.
  function automatic logic lsu_is_w(input logic [2:0] f3);
    return !(lsu_is_b(f3) || lsu_is_h(f3)) || (f3 == LSU_W);
  endfunction

endpackage

// File: rtl/mem_access_stage_align.sv
// Lane steering for stores and lane extraction for loads.
// Unknown size codes fall through to word access.
module lsu_align
  import mem_access_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  a,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic        is_b;
  logic        is_h;
  logic        sgn;
  logic [31:0] shifted;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign is_b    = lsu_is_b(funct3);
  assign is_h    = lsu_is_h(funct3);
  assign sgn     = ~funct3[2];
  assign shifted = rdata >> {a, 3'b000};
  assign lane_b  = shifted[7:0];
  assign lane_h  = a[1] ? rdata[31:16] : rdata[15:0];

  // Decode size into byte enables, store lanes and load extension.
  always_comb begin
    be        = 4'b1111;
    wdata     = store_data;
    load_data = rdata;
    unique case (1'b1)
      is_b: begin
        be        = 4'b0001 << a;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{sgn & lane_b[7]}}, lane_b};
      end
      is_h: begin
        be        = 4'b0011 << {a[1], 1'b0};
        wdata     = {2{store_data[15:0]}};
        load_data = {{16{sgn & lane_h[15]}}, lane_h};
      end
      default: begin
        be        = 4'b1111;
        wdata     = store_data;
        load_data = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: loads/stores over req/ack, writeback packet.
// MEM_ALIGN_CHECK_EN adds misalign_err and skips misaligned accesses.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       alu_out,
  input  logic [DATA_W-1:0] store_data,
  input  logic [4:0]        rd,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              reg_write,
  input  logic [2:0]        funct3,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
`ifdef MEM_ALIGN_CHECK_EN
  output logic              misalign_err,
`endif
  output logic              wb_reg_write
);

  state_t      state_q;
  state_t      state_d;
  wb_pkt_t     wb_q;
  logic        acc;
  logic        is_mem;
  logic        mis;
  logic [2:0]  f3_sel;
  logic [1:0]  a_sel;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_load;

  logic [4:0]  p_rd;
  logic        p_rw;
  logic        p_load;
  logic [2:0]  p_f3;
  logic [1:0]  p_a;
  logic [31:0] p_alu;

  assign in_ready = (state_q == ST_IDLE);
  assign acc      = in_valid && in_ready;
  assign is_mem   = mem_read || mem_write;

  // One aligner: live inputs while idle, held op while busy.
  assign f3_sel = in_ready ? funct3 : p_f3;
  assign a_sel  = in_ready ? alu_out[1:0] : p_a;

`ifdef MEM_ALIGN_CHECK_EN
  logic mis_q;
  assign mis = is_mem &&
    ((lsu_is_h(funct3) && alu_out[0]) ||
     (lsu_is_w(funct3) && (alu_out[1:0] != 2'b00)));
  assign misalign_err = mis_q;
`else
  assign mis = 1'b0;
`endif

  lsu_align u_align (
    .funct3     (f3_sel),
    .a          (a_sel),
    .store_data (store_data),
    .rdata      (dmem_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load)
  );

  assign wb_valid     = wb_q.valid;
  assign wb_rd        = wb_q.rd;
  assign wb_data      = wb_q.data;
  assign wb_reg_write = wb_q.reg_write;

  // Next-state: go busy on an aligned memory op, idle on ack.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (acc && is_mem && !mis) state_d = ST_BUSY;
      ST_BUSY: if (dmem_ack) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Request registers, held op and the writeback packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= 4'b0000;
      dmem_wdata <= '0;
      wb_q       <= '0;
      p_rd       <= '0;
      p_rw       <= 1'b0;
      p_load     <= 1'b0;
      p_f3       <= '0;
      p_a        <= '0;
      p_alu      <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      mis_q      <= 1'b0;
`endif
    end else begin
      wb_q.valid <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      mis_q      <= 1'b0;
`endif
      if (state_q == ST_IDLE) begin
        if (acc && is_mem && !mis) begin
          dmem_req   <= 1'b1;
          dmem_we    <= mem_write && !mem_read;
          dmem_addr  <= {alu_out[ADDR_W-1:2], 2'b00};
          dmem_be    <= al_be;
          dmem_wdata <= al_wdata;
          p_rd       <= rd;
          p_rw       <= reg_write;
          p_load     <= mem_read;
          p_f3       <= funct3;
          p_a        <= alu_out[1:0];
          p_alu      <= alu_out;
        end else if (acc) begin
          wb_q.valid     <= 1'b1;
          wb_q.rd        <= rd;
          wb_q.data      <= alu_out;
          wb_q.reg_write <= reg_write && (rd != 5'd0) && !mis;
`ifdef MEM_ALIGN_CHECK_EN
          mis_q          <= mis;
`endif
        end
      end else if (dmem_ack) begin
        dmem_req       <= 1'b0;
        wb_q.valid     <= 1'b1;
        wb_q.rd        <= p_rd;
        wb_q.data      <= p_load ? al_load : p_alu;
        wb_q.reg_write <= p_load && p_rw && (p_rd != 5'd0);
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage.
// Stimulus pushes expected writebacks; a monitor pops them.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_out;
  logic [31:0] store_data;
  logic [4:0]  rd;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic [2:0]  funct3;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_reg_write;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalign_err;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        rw;
    logic        cd;
    logic        mis;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_out      (alu_out),
    .store_data   (store_data),
    .rd           (rd),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .reg_write    (reg_write),
    .funct3       (funct3),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
`ifdef MEM_ALIGN_CHECK_EN
    .misalign_err (misalign_err),
`endif
    .wb_reg_write (wb_reg_write)
  );

  function automatic void chk(string n, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endfunction

  function automatic void push(logic [4:0] r, logic [31:0] d,
                               logic w, logic c, logic m);
    exp_t e;
    e.rd = r; e.data = d; e.rw = w; e.cd = c; e.mis = m;
    sb.push_back(e);
  endfunction

  // Monitor: every writeback pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (wb_valid) begin
      exp_t e;
      chk("wb_while_busy", {31'd0, in_ready}, 32'd1);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got rd=%0d data=%h expected none",
                 wb_rd, wb_data);
      end else begin
        e = sb.pop_front();
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
        chk("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, e.rw});
        if (e.cd) chk("wb_data", wb_data, e.data);
`ifdef MEM_ALIGN_CHECK_EN
        chk("misalign_err", {31'd0, misalign_err}, {31'd0, e.mis});
`endif
      end
    end
  end

  task automatic set_in(logic [31:0] a, logic [2:0] f3, logic [31:0] sd,
                        logic [4:0] r, logic mr, logic mw, logic rw);
    in_valid   = 1'b1;
    alu_out    = a;
    funct3     = f3;
    store_data = sd;
    rd         = r;
    mem_read   = mr;
    mem_write  = mw;
    reg_write  = rw;
  endtask

  task automatic alu_op(logic [31:0] a, logic [4:0] r, logic rw,
                        logic exp_rw);
    @(negedge clk);
    set_in(a, 3'b000, 32'd0, r, 1'b0, 1'b0, rw);
    push(r, a, exp_rw, 1'b1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("alu_in_ready", {31'd0, in_ready}, 32'd1);
    chk("alu_no_req", {31'd0, dmem_req}, 32'd0);
  endtask

  // Issue one memory op; ack arrives in the n-th request cycle.
  task automatic mem_op(string n, logic [31:0] a, logic [2:0] f3,
                        logic [31:0] sd, logic [4:0] r, logic mr,
                        logic mw, int cyc, logic [31:0] rdata,
                        logic [31:0] e_addr, logic [3:0] e_be,
                        logic [31:0] e_wd, logic e_we,
                        logic [31:0] e_data, logic e_rw);
    @(negedge clk);
    set_in(a, f3, sd, r, mr, mw, 1'b1);
    push(r, e_data, e_rw, mr, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < cyc; i++) begin
      chk({n, "_req"}, {31'd0, dmem_req}, 32'd1);
      chk({n, "_in_ready"}, {31'd0, in_ready}, 32'd0);
      chk({n, "_addr"}, dmem_addr, e_addr);
      chk({n, "_be"}, {28'd0, dmem_be}, {28'd0, e_be});
      chk({n, "_we"}, {31'd0, dmem_we}, {31'd0, e_we});
      if (e_we) chk({n, "_wdata"}, dmem_wdata, e_wd);
      if (i == cyc - 1) begin
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
      end
      @(negedge clk);
    end
    dmem_ack   = 1'b0;
    dmem_rdata = 32'd0;
    chk({n, "_req_drop"}, {31'd0, dmem_req}, 32'd0);
    chk({n, "_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    alu_out    = '0;
    store_data = '0;
    rd         = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    funct3     = '0;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_we", {31'd0, dmem_we}, 32'd0);
    chk("rst_be", {28'd0, dmem_be}, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_rw", {31'd0, wb_reg_write}, 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
    chk("rst_mis", {31'd0, misalign_err}, 32'd0);
`endif
    rst = 1'b0;

    alu_op(32'h0000_0055, 5'd5, 1'b1, 1'b1);
    alu_op(32'h0000_1234, 5'd0, 1'b1, 1'b0);
    alu_op(32'h0000_0077, 5'd6, 1'b0, 1'b0);

    // Back-to-back ALU ops on consecutive cycles.
    @(negedge clk);
    set_in(32'hA5A5_0001, 3'b000, 32'd0, 5'd1, 1'b0, 1'b0, 1'b1);
    push(5'd1, 32'hA5A5_0001, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("b2b_ready", {31'd0, in_ready}, 32'd1);
    set_in(32'hA5A5_0002, 3'b000, 32'd0, 5'd2, 1'b0, 1'b0, 1'b1);
    push(5'd2, 32'hA5A5_0002, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;

    mem_op("sw", 32'h100, 3'b010, 32'hDEAD_BEEF, 5'd3, 1'b0, 1'b1, 3,
           32'd0, 32'h100, 4'b1111, 32'hDEAD_BEEF, 1'b1, 32'd0, 1'b0);
    mem_op("lb", 32'h203, 3'b000, 32'd0, 5'd7, 1'b1, 1'b0, 1,
           32'h8011_2233, 32'h200, 4'b1000, 32'd0, 1'b0,
           32'hFFFF_FF80, 1'b1);
    mem_op("lbu", 32'h203, 3'b100, 32'd0, 5'd7, 1'b1, 1'b0, 2,
           32'h8011_2233, 32'h200, 4'b1000, 32'd0, 1'b0,
           32'h0000_0080, 1'b1);
    mem_op("lbu1", 32'h201, 3'b100, 32'd0, 5'd8, 1'b1, 1'b0, 1,
           32'h8011_2233, 32'h200, 4'b0010, 32'd0, 1'b0,
           32'h0000_0022, 1'b1);
    mem_op("lb2", 32'h202, 3'b000, 32'd0, 5'd8, 1'b1, 1'b0, 1,
           32'h8011_2233, 32'h200, 4'b0100, 32'd0, 1'b0,
           32'h0000_0011, 1'b1);
    mem_op("sh", 32'h302, 3'b001, 32'h0000_ABCD, 5'd0, 1'b0, 1'b1, 2,
           32'd0, 32'h300, 4'b1100, 32'hABCD_ABCD, 1'b1, 32'd0, 1'b0);
    mem_op("lhu", 32'h302, 3'b101, 32'd0, 5'd10, 1'b1, 1'b0, 1,
           32'hABCD_0000, 32'h300, 4'b1100, 32'd0, 1'b0,
           32'h0000_ABCD, 1'b1);
    mem_op("lh", 32'h300, 3'b001, 32'd0, 5'd11, 1'b1, 1'b0, 2,
           32'h1234_8001, 32'h300, 4'b0011, 32'd0, 1'b0,
           32'hFFFF_8001, 1'b1);
    mem_op("sb", 32'h101, 3'b000, 32'h0000_005A, 5'd4, 1'b0, 1'b1, 1,
           32'd0, 32'h100, 4'b0010, 32'h5A5A_5A5A, 1'b1, 32'd0, 1'b0);
    mem_op("lw", 32'h104, 3'b010, 32'd0, 5'd12, 1'b1, 1'b0, 4,
           32'hCAFE_F00D, 32'h104, 4'b1111, 32'd0, 1'b0,
           32'hCAFE_F00D, 1'b1);
    mem_op("rdwr", 32'h108, 3'b010, 32'hFFFF_FFFF, 5'd9, 1'b1, 1'b1, 1,
           32'h1122_3344, 32'h108, 4'b1111, 32'd0, 1'b0,
           32'h1122_3344, 1'b1);
    mem_op("f3bad", 32'h10C, 3'b011, 32'd0, 5'd13, 1'b1, 1'b0, 1,
           32'h55AA_55AA, 32'h10C, 4'b1111, 32'd0, 1'b0,
           32'h55AA_55AA, 1'b1);
    mem_op("lw_rd0", 32'h110, 3'b010, 32'd0, 5'd0, 1'b1, 1'b0, 1,
           32'h0BAD_CAFE, 32'h110, 4'b1111, 32'd0, 1'b0,
           32'h0BAD_CAFE, 1'b0);

`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned word and half: no request, flagged writeback.
    @(negedge clk);
    set_in(32'h101, 3'b010, 32'd0, 5'd15, 1'b1, 1'b0, 1'b1);
    push(5'd15, 32'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mis_lw_req", {31'd0, dmem_req}, 32'd0);
    chk("mis_lw_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    chk("mis_lw_req2", {31'd0, dmem_req}, 32'd0);
    chk("mis_clear", {31'd0, misalign_err}, 32'd0);
    @(negedge clk);
    set_in(32'h303, 3'b001, 32'h1234, 5'd16, 1'b0, 1'b1, 1'b0);
    push(5'd16, 32'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mis_sh_req", {31'd0, dmem_req}, 32'd0);
    mem_op("lh_al", 32'h302, 3'b001, 32'd0, 5'd17, 1'b1, 1'b0, 1,
           32'h8765_0000, 32'h300, 4'b1100, 32'd0, 1'b0,
           32'hFFFF_8765, 1'b1);
`else
    // Without alignment checking misaligned ops proceed.
    mem_op("lw_mis", 32'h101, 3'b010, 32'd0, 5'd15, 1'b1, 1'b0, 1,
           32'h0102_0304, 32'h100, 4'b1111, 32'd0, 1'b0,
           32'h0102_0304, 1'b1);
    mem_op("lh_mis", 32'h303, 3'b001, 32'd0, 5'd16, 1'b1, 1'b0, 2,
           32'hF00D_1234, 32'h300, 4'b1100, 32'd0, 1'b0,
           32'hFFFF_F00D, 1'b1);
`endif

    // Reset mid-load, then a late ack that must be ignored.
    @(negedge clk);
    set_in(32'h400, 3'b010, 32'd0, 5'd14, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("rstmid_req", {31'd0, dmem_req}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_req_drop", {31'd0, dmem_req}, 32'd0);
    chk("rstmid_ready", {31'd0, in_ready}, 32'd1);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h9999_9999;
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("late_ack_req", {31'd0, dmem_req}, 32'd0);
    chk("late_ack_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    alu_op(32'h0000_00C3, 5'd31, 1'b1, 1'b1);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
